// File: rtl/paddle_tracker.sv
// paddle_tracker: tracks the y position of NUM_PADDLES paddles, updates them
// once per frame tick from up/down keys with edge clamping, then streams one
// draw transaction per paddle (index order) over valid/ready.
// Optional feature macro: PADDLE_ACCEL_EN (per-paddle step acceleration).
module paddle_tracker #(
  parameter int unsigned NUM_PADDLES = 2,
  parameter int unsigned IDX_W       = 1,
  parameter int unsigned COORD_W     = 9,
  parameter int unsigned PADDLE_H    = 48,
  parameter int unsigned SCREEN_H    = 240,
  parameter int unsigned RESET_Y     = 96,
  parameter int unsigned STEP        = 1,
  parameter int unsigned MAX_STEP    = 4,
  parameter int unsigned FRAME_COUNT = 3333332
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_PADDLES-1:0]         up,
  input  logic [NUM_PADDLES-1:0]         down,
  input  logic [NUM_PADDLES*COORD_W-1:0] in_x,
  input  logic [NUM_PADDLES*3-1:0]       in_color,
  input  logic                           m_ready,
  output logic                           m_valid,
  output logic [COORD_W-1:0]             out_x,
  output logic [COORD_W-1:0]             out_y,
  output logic [2:0]                     out_color,
  output logic [IDX_W-1:0]               out_index,
  output logic                           out_last
);

  localparam int unsigned EXT_W  = COORD_W + 1;
  localparam int unsigned Y_MAX  = SCREEN_H - PADDLE_H;
  localparam int unsigned STEP_W = $clog2(MAX_STEP + 1);
  localparam int unsigned CNT_W  = (FRAME_COUNT > 0) ? $clog2(FRAME_COUNT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PADDLES - 1);

  typedef enum logic [1:0] {S_INIT, S_WAIT_FRAME, S_UPDATE, S_EMIT} state_t;

  state_t                 state;
  logic                   init_done;
  logic [CNT_W-1:0]       frame_cnt;
  logic [COORD_W-1:0]     y_q      [NUM_PADDLES];
  logic [COORD_W-1:0]     y_nxt    [NUM_PADDLES];
  logic [STEP_W-1:0]      step_cur [NUM_PADDLES];
  logic [NUM_PADDLES-1:0] move_up;
  logic [NUM_PADDLES-1:0] move_dn;
  logic                   last_xfer;
  logic [IDX_W-1:0]       next_idx;

  assign move_up   = up & ~down;
  assign move_dn   = down & ~up;
  assign last_xfer = m_valid && m_ready && (out_index == LAST_IDX);
  assign next_idx  = out_index + IDX_W'(1);

  // x and colour are live pass-through slices of the offered paddle
  assign out_x     = in_x[32'(out_index) * COORD_W +: COORD_W];
  assign out_color = in_color[32'(out_index) * 3 +: 3];

`ifdef PADDLE_ACCEL_EN
  logic [STEP_W-1:0]      step_q [NUM_PADDLES];
  logic [1:0]             dir_q  [NUM_PADDLES];  // {up, down} of the last update
  logic [NUM_PADDLES-1:0] clamp;

  // current move uses the stored per-paddle step
  always_comb begin
    for (int i = 0; i < NUM_PADDLES; i++) begin
      step_cur[i] = step_q[i];
    end
  end

  // a move that would cross a screen edge is a clamp
  always_comb begin
    clamp = '0;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      if (move_up[i] && (EXT_W'(y_q[i]) < EXT_W'(step_q[i])))
        clamp[i] = 1'b1;
      if (move_dn[i] && (EXT_W'(y_q[i]) + EXT_W'(step_q[i]) > EXT_W'(Y_MAX)))
        clamp[i] = 1'b1;
    end
  end

  // step grows on repeated same-direction moves, falls back otherwise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PADDLES; i++) begin
        step_q[i] <= STEP_W'(STEP);
        dir_q[i]  <= 2'b00;
      end
    end else if (state == S_UPDATE) begin
      for (int i = 0; i < NUM_PADDLES; i++) begin
        if (!(move_up[i] || move_dn[i]) || clamp[i] ||
            ((dir_q[i] != 2'b00) && (dir_q[i] != {move_up[i], move_dn[i]})))
          step_q[i] <= STEP_W'(STEP);
        else if (step_q[i] < STEP_W'(MAX_STEP))
          step_q[i] <= step_q[i] + STEP_W'(1);
        dir_q[i] <= {move_up[i], move_dn[i]};
      end
    end
  end
`else
  // fixed step size
  always_comb begin
    for (int i = 0; i < NUM_PADDLES; i++) begin
      step_cur[i] = STEP_W'(STEP);
    end
  end
`endif

  // candidate positions, computed one bit wider so no wrap can occur
  always_comb begin
    for (int i = 0; i < NUM_PADDLES; i++) begin
      y_nxt[i] = y_q[i];
      if (move_up[i]) begin
        if (EXT_W'(y_q[i]) < EXT_W'(step_cur[i]))
          y_nxt[i] = '0;
        else
          y_nxt[i] = COORD_W'(EXT_W'(y_q[i]) - EXT_W'(step_cur[i]));
      end else if (move_dn[i]) begin
        if (EXT_W'(y_q[i]) + EXT_W'(step_cur[i]) > EXT_W'(Y_MAX))
          y_nxt[i] = COORD_W'(Y_MAX);
        else
          y_nxt[i] = COORD_W'(EXT_W'(y_q[i]) + EXT_W'(step_cur[i]));
      end
    end
  end

  // frame counter: cleared by the last-paddle transfer, saturates at FRAME_COUNT
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      frame_cnt <= '0;
    else if (last_xfer)
      frame_cnt <= '0;
    else if (frame_cnt != CNT_W'(FRAME_COUNT))
      frame_cnt <= frame_cnt + CNT_W'(1);
  end

  // control FSM with registered stream outputs and position state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      init_done <= 1'b0;
      m_valid   <= 1'b0;
      out_index <= '0;
      out_y     <= COORD_W'(RESET_Y);
      out_last  <= (LAST_IDX == '0);
      for (int i = 0; i < NUM_PADDLES; i++) begin
        y_q[i] <= COORD_W'(RESET_Y);
      end
    end else begin
      case (state)
        S_INIT: begin
          // first edge after release only settles the deasserted reset
          init_done <= 1'b1;
          if (init_done) begin
            state     <= S_EMIT;
            m_valid   <= 1'b1;
            out_index <= '0;
            out_y     <= y_q[0];
            out_last  <= (LAST_IDX == '0);
          end
        end
        S_WAIT_FRAME: begin
          if (frame_cnt == CNT_W'(FRAME_COUNT))
            state <= S_UPDATE;
        end
        S_UPDATE: begin
          for (int i = 0; i < NUM_PADDLES; i++) begin
            y_q[i] <= y_nxt[i];
          end
          state     <= S_EMIT;
          m_valid   <= 1'b1;
          out_index <= '0;
          out_y     <= y_nxt[0];
          out_last  <= (LAST_IDX == '0);
        end
        S_EMIT: begin
          if (m_ready) begin
            if (out_index == LAST_IDX) begin
              state     <= S_WAIT_FRAME;
              m_valid   <= 1'b0;
              out_index <= '0;
              out_y     <= y_q[0];
              out_last  <= (LAST_IDX == '0);
            end else begin
              out_index <= next_idx;
              out_y     <= y_q[next_idx];
              out_last  <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_tracker.sv
// Self-checking bench for paddle_tracker (default build, two paddles,
// STEP=3, RESET_Y=97, FRAME_COUNT=4 so one frame is 8 cycles).
module tb_paddle_tracker;

  localparam int unsigned NP = 2;
  localparam int unsigned CW = 9;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NP-1:0]   up;
  logic [NP-1:0]   down;
  logic [NP*CW-1:0] in_x;
  logic [NP*3-1:0] in_color;
  logic            m_ready;
  logic            m_valid;
  logic [CW-1:0]   out_x;
  logic [CW-1:0]   out_y;
  logic [2:0]      out_color;
  logic [0:0]      out_index;
  logic            out_last;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  paddle_tracker #(
    .NUM_PADDLES(NP), .IDX_W(1), .COORD_W(CW), .PADDLE_H(48), .SCREEN_H(240),
    .RESET_Y(97), .STEP(3), .MAX_STEP(4), .FRAME_COUNT(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .up(up), .down(down),
    .in_x(in_x), .in_color(in_color), .m_ready(m_ready),
    .m_valid(m_valid), .out_x(out_x), .out_y(out_y), .out_color(out_color),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] up;
    logic [1:0] down;
    int         y0;
    int         y1;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // wait (bounded) for m_valid, sampling on falling edges
  task automatic wait_valid(output int at);
    int n;
    n = 0;
    while (!m_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("wait_valid", int'(m_valid), 1);
    at = cyc;
  endtask

  // consume one full emission with m_ready high, returning both y values
  task automatic emit_collect(output int y0, output int y1);
    y0 = -1;
    y1 = -1;
    for (int i = 0; i < 2; i++) begin
      check("emit_valid", int'(m_valid), 1);
      check("emit_index", int'(out_index), i);
      check("emit_last", int'(out_last), (i == 1) ? 1 : 0);
      check("emit_x", int'(out_x), (i == 0) ? 20 : 300);
      check("emit_color", int'(out_color), (i == 0) ? 2 : 5);
      if (i == 0) y0 = int'(out_y);
      else        y1 = int'(out_y);
      @(negedge clock);
    end
    check("emit_done", int'(m_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int y0, y1, t, prev, t_x;

    vecs[0] = '{up: 2'b01, down: 2'b10, y0: 94, y1: 100};
    vecs[1] = '{up: 2'b11, down: 2'b01, y0: 94, y1: 97};
    vecs[2] = '{up: 2'b00, down: 2'b00, y0: 94, y1: 97};
    vecs[3] = '{up: 2'b00, down: 2'b11, y0: 97, y1: 100};
    vecs[4] = '{up: 2'b10, down: 2'b00, y0: 97, y1: 97};

    reset_n  = 1'b0;
    up       = '0;
    down     = '0;
    m_ready  = 1'b1;
    in_x     = {9'd300, 9'd20};
    in_color = {3'd5, 3'd2};

    // reset state
    repeat (3) @(negedge clock);
    check("rst_valid", int'(m_valid), 0);
    check("rst_index", int'(out_index), 0);
    check("rst_y", int'(out_y), 97);

    // initial draw: valid on the second edge after release, keys irrelevant
    reset_n = 1'b1;
    up      = 2'b11;
    @(negedge clock);
    check("init_hold", int'(m_valid), 0);
    @(negedge clock);
    check("init_valid", int'(m_valid), 1);
    prev = cyc;
    emit_collect(y0, y1);
    check("init_y0", y0, 97);
    check("init_y1", y1, 97);

    // table-driven frames
    for (int k = 0; k < 5; k++) begin
      up   = vecs[k].up;
      down = vecs[k].down;
      wait_valid(t);
      check("frame_period", t - prev, 8);
      prev = t;
      emit_collect(y0, y1);
      check("vec_y0", y0, vecs[k].y0);
      check("vec_y1", y1, vecs[k].y1);
    end

    // drive paddle 0 up and paddle 1 down toward the screen edges
    up   = 2'b01;
    down = 2'b10;
    for (int k = 1; k <= 31; k++) begin
      wait_valid(t);
      prev = t;
      emit_collect(y0, y1);
      check("ramp_y0", y0, 97 - 3 * k);
      check("ramp_y1", y1, 97 + 3 * k);
    end
    wait_valid(t);
    prev = t;
    emit_collect(y0, y1);
    check("near_top_y0", y0, 1);
    check("clamp_bottom_y1", y1, 192);
    wait_valid(t);
    prev = t;
    emit_collect(y0, y1);
    check("clamp_top_y0", y0, 0);
    check("hold_bottom_y1", y1, 192);
    wait_valid(t);
    prev = t;
    emit_collect(y0, y1);
    check("stay_top_y0", y0, 0);
    check("stay_bottom_y1", y1, 192);

    // keys outside the update cycle are ignored
    up   = 2'b10;
    down = 2'b01;
    repeat (3) @(negedge clock);
    up   = 2'b00;
    down = 2'b00;
    wait_valid(t);
    check("ignore_period", t - prev, 8);
    prev = t;
    up   = 2'b10;
    down = 2'b01;
    emit_collect(y0, y1);
    up   = 2'b00;
    down = 2'b00;
    check("ignore_y0", y0, 0);
    check("ignore_y1", y1, 192);

    // backpressure on both indices
    down    = 2'b01;
    m_ready = 1'b0;
    wait_valid(t);
    check("stall_period", t - prev, 8);
    prev = t;
    for (int s = 0; s < 5; s++) begin
      check("stall_valid", int'(m_valid), 1);
      check("stall_index", int'(out_index), 0);
      check("stall_y", int'(out_y), 3);
      @(negedge clock);
    end
    m_ready = 1'b1;
    @(negedge clock);
    m_ready = 1'b0;
    check("stall1_index", int'(out_index), 1);
    check("stall1_y", int'(out_y), 192);
    check("stall1_last", int'(out_last), 1);
    @(negedge clock);
    check("stall1_hold_valid", int'(m_valid), 1);
    check("stall1_hold_index", int'(out_index), 1);
    m_ready = 1'b1;
    @(negedge clock);
    check("stall_done", int'(m_valid), 0);
    t_x  = cyc;
    down = 2'b00;
    wait_valid(t);
    check("post_stall_gap", t - t_x, 6);

    // asynchronous reset in the middle of an emission
    m_ready = 1'b0;
    check("pre_rst_y0", int'(out_y), 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", int'(m_valid), 0);
    check("rst_mid_index", int'(out_index), 0);
    check("rst_mid_y", int'(out_y), 97);
    @(negedge clock);
    reset_n = 1'b1;
    m_ready = 1'b1;
    @(negedge clock);
    check("rerst_hold", int'(m_valid), 0);
    @(negedge clock);
    emit_collect(y0, y1);
    check("rerst_y0", y0, 97);
    check("rerst_y1", y1, 97);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
